// File: rtl/ln_seq_pkg.sv
// Shared types and IEEE-754 single-precision constants for the ln sample sequencer.
package ln_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_NORM     = 3'd1,
        ST_FSM_RST  = 3'd2,
        ST_START    = 3'd3,
        ST_WAIT_ACK = 3'd4,
        ST_DONE     = 3'd5
    } ln_state_e;

    localparam int FP_BIAS   = 127;
    localparam int FP_MANT_W = 23;
    localparam int FP_EXP_W  = 8;

    localparam logic [31:0] NEG_INF = 32'hFF80_0000;
    localparam logic [31:0] QNAN    = 32'h7FC0_0000;

    function automatic logic [31:0] fp_pack(input logic                 sign,
                                             input logic [FP_EXP_W-1:0]  exp_f,
                                             input logic [FP_MANT_W-1:0] mant_f);
        return {sign, exp_f, mant_f};
    endfunction

endpackage

// File: rtl/uint_to_fp_norm.sv
// Iterative normalizer: shifts a nonzero unsigned code left one bit per cycle until
// its MSB is set, then presents the exact single-precision value of the original code.
module uint_to_fp_norm
    import ln_seq_pkg::*;
#(
    parameter int ADC_W = 12
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [ADC_W-1:0] i_sample,
    output logic             o_done,
    output logic [31:0]      o_fp
);

    localparam int CNT_W = $clog2(ADC_W);

    logic [ADC_W-1:0]     r_shift;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_busy;
    logic [FP_EXP_W-1:0]  w_exp;
    logic [FP_MANT_W-1:0] w_mant;

    // Load, then shift until the leading one reaches the MSB
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_shift <= {ADC_W{1'b0}};
            r_cnt   <= {CNT_W{1'b0}};
            r_busy  <= 1'b0;
        end else if (i_load) begin
            r_shift <= i_sample;
            r_cnt   <= {CNT_W{1'b0}};
            r_busy  <= 1'b1;
        end else if (r_busy) begin
            if (r_shift[ADC_W-1]) begin
                r_busy <= 1'b0;
            end else begin
                r_shift <= r_shift << 1;
                r_cnt   <= r_cnt + CNT_W'(1);
            end
        end
    end

    // The leading one is implicit; the remaining bits become the top of the mantissa
    always_comb begin
        w_exp  = FP_EXP_W'(FP_BIAS + ADC_W - 1) - FP_EXP_W'(r_cnt);
        w_mant = FP_MANT_W'(r_shift[ADC_W-2:0]) << (FP_MANT_W - (ADC_W - 1));
        o_fp   = fp_pack(1'b0, w_exp, w_mant);
        o_done = r_busy & r_shift[ADC_W-1];
    end

endmodule

// File: rtl/ln_sample_sequencer.sv
// Feeds one ADC sample at a time to the CORDIC ln linearizer and returns its result.
// Optional build macro LN_TIMEOUT_EN bounds the wait for ACK_LN to TIMEOUT_CYC cycles.
module ln_sample_sequencer
    import ln_seq_pkg::*;
#(
    parameter int P           = 32,
    parameter int ADC_W       = 12,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [ADC_W-1:0] SAMPLE,
    input  logic             SAMPLE_VALID,
    output logic             SAMPLE_RDY,
    output logic [P-1:0]     T,
    output logic             RST_FSM_LN,
    output logic             Begin_FSM_LN,
    input  logic             ACK_LN,
    input  logic [P-1:0]     RESULT,
    input  logic             O_F,
    input  logic             U_F,
    output logic             LN_VALID,
    input  logic             LN_READY,
    output logic [P-1:0]     LN_RESULT,
    output logic             LN_OF,
    output logic             LN_UF,
    output logic             ZERO_ERR,
    output logic             TIMEOUT_ERR
);

    if (P != 32) begin : g_bad_p
        $error("ln_sample_sequencer: only P=32 is supported");
    end
    if (ADC_W < 2 || ADC_W > 24) begin : g_bad_adc_w
        $error("ln_sample_sequencer: ADC_W must be in 2..24");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("ln_sample_sequencer: TIMEOUT_CYC must be at least 1");
    end

    ln_state_e      r_state, w_next_state;
    logic           r_sample_rdy, r_rst_fsm, r_begin_fsm, r_ln_valid;
    logic [P-1:0]   r_t, r_ln_result;
    logic           r_ln_of, r_ln_uf, r_zero_err, r_timeout_err;
    logic           w_rdy_nx, w_rst_fsm_nx, w_begin_nx, w_valid_nx;
    logic [P-1:0]   w_t_nx, w_res_nx;
    logic           w_of_nx, w_uf_nx, w_zero_nx, w_to_nx;
    logic           w_sample_zero, w_norm_load, w_norm_done, w_timeout;
    logic [31:0]    w_norm_fp;

    assign w_sample_zero = (SAMPLE == {ADC_W{1'b0}});
    assign w_norm_load   = (r_state == ST_IDLE) && SAMPLE_VALID && !w_sample_zero;

    uint_to_fp_norm #(.ADC_W(ADC_W)) u_norm (
        .i_clk    (CLK),
        .i_rst    (RST),
        .i_load   (w_norm_load),
        .i_sample (SAMPLE),
        .o_done   (w_norm_done),
        .o_fp     (w_norm_fp)
    );

`ifdef LN_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] r_to_cnt;

    // Counts WAIT_ACK cycles; restarts from zero on every entry
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_to_cnt <= {TO_W{1'b0}};
        end else if (r_state == ST_WAIT_ACK) begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
        end else begin
            r_to_cnt <= {TO_W{1'b0}};
        end
    end

    assign w_timeout = (r_state == ST_WAIT_ACK) && (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (SAMPLE_VALID) begin
                    w_next_state = w_sample_zero ? ST_DONE : ST_NORM;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_NORM: begin
                if (w_norm_done) begin
                    w_next_state = ST_FSM_RST;
                end else begin
                    w_next_state = ST_NORM;
                end
            end
            ST_FSM_RST:  w_next_state = ST_START;
            ST_START:    w_next_state = ST_WAIT_ACK;
            ST_WAIT_ACK: begin
                if (ACK_LN || w_timeout) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_WAIT_ACK;
                end
            end
            ST_DONE: begin
                if (LN_READY) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_DONE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs, keyed off the transition
    always_comb begin
        w_rdy_nx     = (w_next_state == ST_IDLE);
        w_rst_fsm_nx = (w_next_state == ST_FSM_RST);
        w_begin_nx   = (w_next_state == ST_START);
        w_valid_nx   = (w_next_state == ST_DONE);
        w_t_nx       = r_t;
        w_res_nx     = r_ln_result;
        w_of_nx      = r_ln_of;
        w_uf_nx      = r_ln_uf;
        w_zero_nx    = r_zero_err;
        w_to_nx      = r_timeout_err;
        case (r_state)
            ST_IDLE: begin
                if (SAMPLE_VALID && w_sample_zero) begin
                    w_res_nx  = NEG_INF;
                    w_of_nx   = 1'b0;
                    w_uf_nx   = 1'b0;
                    w_zero_nx = 1'b1;
                end else begin
                    w_zero_nx = r_zero_err;
                end
            end
            ST_NORM: begin
                if (w_norm_done) begin
                    w_t_nx = w_norm_fp;
                end else begin
                    w_t_nx = r_t;
                end
            end
            ST_WAIT_ACK: begin
                if (ACK_LN) begin
                    w_res_nx = RESULT;
                    w_of_nx  = O_F;
                    w_uf_nx  = U_F;
                end else if (w_timeout) begin
                    w_res_nx = QNAN;
                    w_of_nx  = 1'b0;
                    w_uf_nx  = 1'b0;
                    w_to_nx  = 1'b1;
                end else begin
                    w_res_nx = r_ln_result;
                end
            end
            ST_DONE: begin
                if (LN_READY) begin
                    w_zero_nx = 1'b0;
                    w_to_nx   = 1'b0;
                end else begin
                    w_zero_nx = r_zero_err;
                end
            end
            default: begin
                w_t_nx = r_t;
            end
        endcase
    end

    // Output registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sample_rdy  <= 1'b0;
            r_rst_fsm     <= 1'b0;
            r_begin_fsm   <= 1'b0;
            r_ln_valid    <= 1'b0;
            r_t           <= {P{1'b0}};
            r_ln_result   <= {P{1'b0}};
            r_ln_of       <= 1'b0;
            r_ln_uf       <= 1'b0;
            r_zero_err    <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_sample_rdy  <= w_rdy_nx;
            r_rst_fsm     <= w_rst_fsm_nx;
            r_begin_fsm   <= w_begin_nx;
            r_ln_valid    <= w_valid_nx;
            r_t           <= w_t_nx;
            r_ln_result   <= w_res_nx;
            r_ln_of       <= w_of_nx;
            r_ln_uf       <= w_uf_nx;
            r_zero_err    <= w_zero_nx;
            r_timeout_err <= w_to_nx;
        end
    end

    assign SAMPLE_RDY   = r_sample_rdy;
    assign RST_FSM_LN   = r_rst_fsm;
    assign Begin_FSM_LN = r_begin_fsm;
    assign LN_VALID     = r_ln_valid;
    assign T            = r_t;
    assign LN_RESULT    = r_ln_result;
    assign LN_OF        = r_ln_of;
    assign LN_UF        = r_ln_uf;
    assign ZERO_ERR     = r_zero_err;
    assign TIMEOUT_ERR  = r_timeout_err;

endmodule

// File: tb/tb_ln_sample_sequencer.sv
// Directed bench for ln_sample_sequencer with a scoreboard of expected linearizer results.
module tb_ln_sample_sequencer;

    localparam int ADC_W = 12;

    typedef struct packed {
        logic [31:0] t;
        logic [31:0] res;
        logic        of;
        logic        uf;
        logic        zerr;
    } exp_t;

    logic        CLK, RST;
    logic [11:0] SAMPLE;
    logic        SAMPLE_VALID, SAMPLE_RDY;
    logic [31:0] T;
    logic        RST_FSM_LN, Begin_FSM_LN, ACK_LN;
    logic [31:0] RESULT;
    logic        O_F, U_F, LN_VALID, LN_READY;
    logic [31:0] LN_RESULT;
    logic        LN_OF, LN_UF, ZERO_ERR, TIMEOUT_ERR;

    int   n_cmp = 0;
    int   n_mis = 0;
    exp_t sb[$];

    ln_sample_sequencer #(.P(32), .ADC_W(ADC_W), .TIMEOUT_CYC(15)) dut (
        .CLK(CLK), .RST(RST), .SAMPLE(SAMPLE), .SAMPLE_VALID(SAMPLE_VALID),
        .SAMPLE_RDY(SAMPLE_RDY), .T(T), .RST_FSM_LN(RST_FSM_LN), .Begin_FSM_LN(Begin_FSM_LN),
        .ACK_LN(ACK_LN), .RESULT(RESULT), .O_F(O_F), .U_F(U_F), .LN_VALID(LN_VALID),
        .LN_READY(LN_READY), .LN_RESULT(LN_RESULT), .LN_OF(LN_OF), .LN_UF(LN_UF),
        .ZERO_ERR(ZERO_ERR), .TIMEOUT_ERR(TIMEOUT_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Position of the highest set bit of a nonzero code
    function automatic int msb_pos(input logic [11:0] s);
        int p = 0;
        for (int i = 0; i < ADC_W; i++) if (s[i]) p = i;
        return p;
    endfunction

    // Exact float of an integer: 2^p * (1 + (s - 2^p) / 2^p)
    function automatic logic [31:0] ref_fp(input logic [11:0] s);
        int          p;
        logic [31:0] frac;
        p    = msb_pos(s);
        frac = (32'(s) - (32'd1 << p)) << (23 - p);
        return {1'b0, 8'(127 + p), frac[22:0]};
    endfunction

    task automatic run_sample(input logic [11:0] s, input logic [31:0] t_exp,
                              input logic [31:0] res, input logic of, input logic uf,
                              input int dly, input int stall);
        exp_t        e, got;
        int          cyc, rst_first, beg_first, nrst, nbeg, lz;
        logic [31:0] t_seen, snap;
        logic        stable;
        e.zerr = (s == 12'd0);
        e.t    = t_exp;
        e.res  = e.zerr ? 32'hFF80_0000 : res;
        e.of   = e.zerr ? 1'b0 : of;
        e.uf   = e.zerr ? 1'b0 : uf;
        lz     = e.zerr ? 0 : (ADC_W - 1 - msb_pos(s));
        chk("rdy_idle", {31'd0, SAMPLE_RDY}, 32'd1);
        sb.push_back(e);
        SAMPLE = s; SAMPLE_VALID = 1'b1; RESULT = res; O_F = of; U_F = uf;
        tick();
        SAMPLE_VALID = 1'b0;
        cyc = 1; rst_first = -1; beg_first = -1; nrst = 0; nbeg = 0; t_seen = 32'd0;
        while (!LN_VALID && cyc < 200) begin
            if (RST_FSM_LN) begin nrst++; if (rst_first < 0) rst_first = cyc; end
            if (Begin_FSM_LN) begin nbeg++; if (beg_first < 0) begin beg_first = cyc; t_seen = T; end end
            ACK_LN = (beg_first >= 0) && (cyc == beg_first + 1 + dly);
            tick();
            cyc++;
        end
        ACK_LN = 1'b0;
        chk("ln_valid", {31'd0, LN_VALID}, 32'd1);
        chk("valid_cycle", cyc, e.zerr ? 32'd1 : 32'(lz + 5 + dly));
        chk("rst_pulses", nrst, e.zerr ? 32'd0 : 32'd1);
        chk("begin_pulses", nbeg, e.zerr ? 32'd0 : 32'd1);
        if (!e.zerr) begin
            chk("rst_cycle", rst_first, 32'(lz + 2));
            chk("begin_cycle", beg_first, 32'(lz + 3));
        end
        chk("sb_nonempty", {31'd0, (sb.size() > 0)}, 32'd1);
        got = (sb.size() > 0) ? sb.pop_front() : '0;
        if (!e.zerr) chk("t_value", t_seen, got.t);
        chk("ln_result", LN_RESULT, got.res);
        chk("ln_of", {31'd0, LN_OF}, {31'd0, got.of});
        chk("ln_uf", {31'd0, LN_UF}, {31'd0, got.uf});
        chk("zero_err", {31'd0, ZERO_ERR}, {31'd0, got.zerr});
        chk("timeout_err", {31'd0, TIMEOUT_ERR}, 32'd0);
        if (stall > 0) begin
            snap = LN_RESULT; stable = 1'b1;
            SAMPLE = 12'h5A5; SAMPLE_VALID = 1'b1;
            repeat (stall) begin
                tick();
                stable &= LN_VALID && (LN_RESULT === snap) && (LN_OF === got.of) &&
                          (LN_UF === got.uf) && !SAMPLE_RDY && !RST_FSM_LN && !Begin_FSM_LN;
            end
            SAMPLE_VALID = 1'b0;
            chk("stall_stable", {31'd0, stable}, 32'd1);
        end
        LN_READY = 1'b1;
        tick();
        LN_READY = 1'b0;
        chk("valid_drop", {31'd0, LN_VALID}, 32'd0);
        chk("rdy_after_hs", {31'd0, SAMPLE_RDY}, 32'd1);
        chk("zero_err_clr", {31'd0, ZERO_ERR}, 32'd0);
    endtask

    initial begin
        int          cyc, beg;
        logic [11:0] rs;
        RST = 1'b1; SAMPLE = 12'd0; SAMPLE_VALID = 1'b0; ACK_LN = 1'b0;
        RESULT = 32'd0; O_F = 1'b0; U_F = 1'b0; LN_READY = 1'b0;
        repeat (3) tick();
        chk("rst_rdy", {31'd0, SAMPLE_RDY}, 32'd0);
        chk("rst_valid", {31'd0, LN_VALID}, 32'd0);
        chk("rst_t", T, 32'd0);
        chk("rst_pulses", {30'd0, RST_FSM_LN, Begin_FSM_LN}, 32'd0);
        chk("rst_flags", {29'd0, ZERO_ERR, TIMEOUT_ERR, LN_OF}, 32'd0);
        RST = 1'b0;
        tick();
        chk("rdy_after_rst", {31'd0, SAMPLE_RDY}, 32'd1);

        run_sample(12'd4095, 32'h457F_F000, 32'h4105_1592, 1'b0, 1'b0, 0, 0);
        run_sample(12'd1,    32'h3F80_0000, 32'h0000_0000, 1'b0, 1'b1, 1, 0);
        run_sample(12'd2048, 32'h4500_0000, 32'h40F4_0E5C, 1'b1, 1'b0, 3, 0);
        run_sample(12'd0,    32'h0000_0000, 32'h1234_5678, 1'b1, 1'b1, 0, 6);
        run_sample(12'd37,   ref_fp(12'd37), 32'h4066_2A35, 1'b1, 1'b1, 2, 20);
        for (int k = 0; k < 3; k++) begin
            rs = 12'($urandom_range(1, 4095));
            run_sample(rs, ref_fp(rs), $urandom, 1'($urandom), 1'($urandom), k, 0);
        end

        // Abort a conversion while waiting for the linearizer, then send a late ACK
        SAMPLE = 12'd100; SAMPLE_VALID = 1'b1;
        tick();
        SAMPLE_VALID = 1'b0;
        cyc = 0;
        while (!Begin_FSM_LN && cyc < 50) begin tick(); cyc++; end
        chk("abort_begin_seen", {31'd0, Begin_FSM_LN}, 32'd1);
        repeat (3) tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("abort_outputs", {28'd0, SAMPLE_RDY, LN_VALID, RST_FSM_LN, Begin_FSM_LN}, 32'd0);
        chk("abort_t", T, 32'd0);
        ACK_LN = 1'b1; RESULT = 32'hDEAD_BEEF;
        tick();
        chk("late_ack_rdy", {31'd0, SAMPLE_RDY}, 32'd1);
        tick();
        chk("late_ack_quiet", {29'd0, LN_VALID, RST_FSM_LN, Begin_FSM_LN}, 32'd0);
        ACK_LN = 1'b0;
        run_sample(12'd100, ref_fp(12'd100), 32'h4093_5D8E, 1'b0, 1'b0, 0, 0);

`ifdef LN_TIMEOUT_EN
        SAMPLE = 12'd5; SAMPLE_VALID = 1'b1;
        tick();
        SAMPLE_VALID = 1'b0;
        cyc = 1; beg = -1;
        while (!LN_VALID && cyc < 100) begin
            if (Begin_FSM_LN && beg < 0) beg = cyc;
            tick();
            cyc++;
        end
        chk("to_valid", {31'd0, LN_VALID}, 32'd1);
        chk("to_cycle", cyc, 32'(beg + 16));
        chk("to_err", {31'd0, TIMEOUT_ERR}, 32'd1);
        chk("to_result", LN_RESULT, 32'h7FC0_0000);
        chk("to_flags", {30'd0, LN_OF, LN_UF}, 32'd0);
        LN_READY = 1'b1;
        tick();
        LN_READY = 1'b0;
        chk("to_err_clr", {31'd0, TIMEOUT_ERR}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/ln_sample_sequencer.md
# ln_sample_sequencer

Upstream feeder for the CORDIC natural-log linearizer. Accepts unsigned ADC samples over a valid/ready handshake and converts each to IEEE-754 single precision by iterative normalization. It then sequences the linearizer's FSM reset, start and acknowledge signals, and returns the captured ln result with its flags over a second valid/ready handshake. One sample is in flight at a time.

## Interface
Parameters:
- P, 32, float width; only 32 supported
- ADC_W, 12, sample width; legal range 2..24, so conversion is exact
- TIMEOUT_CYC, 1023, maximum WAIT_ACK cycles; used only with LN_TIMEOUT_EN

Ports:
- CLK  in  1  system clock
- RST  in  1  reset, synchronous, active-high
- SAMPLE  in  ADC_W  unsigned ADC code
- SAMPLE_VALID  in  1  sample offered
- SAMPLE_RDY  out  1  block can accept a sample
- T  out  P  float argument to linearizer; held stable from FSM_RST through WAIT_ACK
- RST_FSM_LN  out  1  linearizer FSM reset pulse
- Begin_FSM_LN  out  1  linearizer start pulse
- ACK_LN  in  1  linearizer done
- RESULT  in  P  linearizer result
- O_F, U_F  in  1 each  linearizer overflow/underflow
- LN_VALID  out  1  result available
- LN_READY  in  1  consumer accepts result
- LN_RESULT  out  P  captured result
- LN_OF, LN_UF  out  1 each  captured flags
- ZERO_ERR  out  1  sample was 0; ln undefined; LN_RESULT = 0xFF800000 (-inf)
- TIMEOUT_ERR  out  1  ACK_LN not seen within limit (tied 0 without macro)

## Operation
- States: IDLE, NORM, FSM_RST, START, WAIT_ACK, DONE.
- IDLE
  - SAMPLE_RDY=1.
  - On SAMPLE_VALID: load SAMPLE into shift register, clear exponent-shift counter.
  - Nonzero sample → NORM. Zero sample → DONE with ZERO_ERR=1; no linearizer activity.
- NORM
  - While shift-register MSB is 0: shift left 1, counter+1, one bit per cycle.
  - When MSB is 1: build T:
    - sign 0
    - exponent = 127 + (ADC_W-1) - count
    - mantissa = shift-register bits [ADC_W-2:0], left-aligned into 23 bits, zero-filled
  - Then → FSM_RST.
- FSM_RST: RST_FSM_LN=1 for exactly one cycle → START.
- START: Begin_FSM_LN=1 for exactly one cycle → WAIT_ACK.
- WAIT_ACK: on first cycle with ACK_LN=1, capture RESULT, O_F, U_F → DONE.
- DONE
  - LN_VALID=1; outputs held until LN_READY=1.
  - On LN_VALID & LN_READY → IDLE.
  - Error flags clear on exit.
- ACK_LN is ignored outside WAIT_ACK. A stale ACK is removed by the RST_FSM_LN pulse.
- SAMPLE_VALID is ignored outside IDLE; no buffering.

## Timing
- Reset values: all outputs 0, state IDLE. SAMPLE_RDY becomes 1 the cycle after RST deasserts.
- RST asserted in any state, including mid-WAIT_ACK:
  - next cycle IDLE, all outputs 0
  - linearizer is not pulsed
  - in-flight result is discarded
- Acceptance at cycle 0. NORM occupies 1 + leading-zero count (max ADC_W) cycles. FSM_RST and START take 1 cycle each. Begin_FSM_LN rises at cycle LZ+3.
- LN_VALID rises the cycle after ACK_LN is sampled.
- Zero sample: LN_VALID at cycle 1.
- Back-to-back: SAMPLE_RDY rises the cycle after the LN handshake completes.

## Configuration
- LN_TIMEOUT_EN defined:
  - WAIT_ACK counter; after TIMEOUT_CYC cycles without ACK_LN → DONE
  - TIMEOUT_ERR=1, LN_RESULT=0x7FC00000 (qNaN), flags 0
- Macro undefined:
  - no counter
  - WAIT_ACK waits indefinitely
  - TIMEOUT_ERR tied 0

## Structure
- Package ln_seq_pkg:
  - state enum
  - FP_BIAS=127, FP_MANT_W=23, FP_EXP_W=8
  - NEG_INF=32'hFF800000, QNAN=32'h7FC00000
- Sub-module uint_to_fp_norm: the iterative shift/count normalizer with start/done. The top level holds the handshake FSM.

## Test plan
- ADC_W=12, SAMPLE=4095 → T=0x457FF000; NORM 1 cycle; one RST_FSM_LN pulse, then one Begin_FSM_LN pulse. ACK_LN with RESULT=0x41051592 → LN_RESULT=0x41051592, LN_VALID=1.
- SAMPLE=1 → T=0x3F800000 after 12 NORM cycles. SAMPLE=2048 → T=0x45000000.
- SAMPLE=0 → ZERO_ERR=1, LN_RESULT=0xFF800000 at cycle 1; RST_FSM_LN and Begin_FSM_LN never asserted.
- LN_READY held low 20 cycles → LN_VALID, LN_RESULT, LN_OF, LN_UF stable; SAMPLE_RDY=0 and new SAMPLE_VALID ignored.
- RST pulsed mid-WAIT_ACK, then late ACK_LN=1 → no LN_VALID; block accepts next sample normally.
- LN_TIMEOUT_EN, TIMEOUT_CYC=15, ACK_LN held 0 → TIMEOUT_ERR=1 and LN_RESULT=0x7FC00000 after 15 WAIT_ACK cycles.
